adder_rr_scheduler: RTL and testbench

- Shares one combinational 32-bit full adder (FullAdder32 instance, external to this block) among NUM_REQ requesters.
- Round-robin arbitration picks one requester. Its operands are captured, driven onto the adder for one cycle, and the registered result is returned with the requester ID over a valid/ready response channel.
- Sits between the requester fabric and the shared adder in the arithmetic test designs.

---
 rtl/adder_rr_scheduler_if.sv | 38 +++
 rtl/adder_rr_scheduler.sv | 116 +++++++++++
 tb/tb_adder_rr_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_rr_scheduler_if.sv
// Request, shared-adder and response signals of adder_rr_scheduler.
// master = requester/adder/consumer side, slave = the scheduler itself.
interface adder_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_cin;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_cout;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic [IDW-1:0]           rsp_id;
  logic                     busy;
  logic [CNT_W-1:0]         ops_done;

  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout,
           rsp_id, busy, ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout,
           rsp_id, busy, ops_done
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational adder among NUM_REQ
// requesters: IDLE grants and captures, EXEC drives the adder, RESP returns the sum.
module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst_n,
  adder_rr_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_reg, state_next;
  logic [IDW-1:0]     rr_ptr_reg;
  logic [IDW-1:0]     winner;
  logic               found;
  logic [NUM_REQ-1:0] ready_vec;
  int                 idx;
  logic [IDW-1:0]     idx_w;

  logic [WIDTH-1:0]   a_arr [NUM_REQ];
  logic [WIDTH-1:0]   b_arr [NUM_REQ];

  logic [WIDTH-1:0]   op_a_reg, op_b_reg;
  logic               op_cin_reg;
  logic [IDW-1:0]     op_id_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               cout_reg;
  logic [IDW-1:0]     id_reg;
  logic [CNT_W-1:0]   ops_done_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = IDW'(idx);
      if (!found && bus.req_valid[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (rst_n && (state_reg == IDLE) && found) ready_vec[winner] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      op_cin_reg   <= 1'b0;
      op_id_reg    <= '0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      id_reg       <= '0;
      ops_done_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && found) begin
        op_a_reg   <= a_arr[winner];
        op_b_reg   <= b_arr[winner];
        op_cin_reg <= bus.req_cin[winner];
        op_id_reg  <= winner;
        rr_ptr_reg <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      if (state_reg == EXEC) begin
        sum_reg  <= bus.add_sum;
        cout_reg <= bus.add_cout;
        id_reg   <= op_id_reg;
      end
      if ((state_reg == RESP) && bus.rsp_ready) ops_done_reg <= ops_done_reg + 1'b1;
    end
  end

  // Operand registers only change on capture, so the adder inputs hold between operations.
  assign bus.add_a     = op_a_reg;
  assign bus.add_b     = op_b_reg;
  assign bus.add_cin   = op_cin_reg;
  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_cout  = cout_reg;
  assign bus.rsp_id    = id_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.ops_done  = ops_done_reg;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler: grants push expected sums, responses pop and
// compare; a small round-robin model predicts req_ready, busy and rsp_valid every cycle.
module tb_adder_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int IDW     = 2;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW), .CNT_W(CNT_W)) bus ();

  adder_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared combinational adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                     + {{WIDTH{1'b0}}, bus.add_cin};

  logic [NUM_REQ-1:0] v;
  logic [WIDTH-1:0]   a_op [NUM_REQ];
  logic [WIDTH-1:0]   b_op [NUM_REQ];
  logic [NUM_REQ-1:0] cin_op;
  logic               rr;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
      assign bus.req_a[gi*WIDTH +: WIDTH] = a_op[gi];
      assign bus.req_b[gi*WIDTH +: WIDTH] = b_op[gi];
    end
  endgenerate
  assign bus.req_valid = v;
  assign bus.req_cin   = cin_op;
  assign bus.rsp_ready = rr;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [WIDTH:0] res;
  } exp_t;

  exp_t               sb [$];
  int                 grant_log [$];
  int                 resp_cyc [$];
  int                 checks = 0;
  int                 errors = 0;
  int                 cyc = 0;
  int                 grant_cyc = 0;
  int                 ptr_m = 0;
  int                 exp_done = 0;
  int                 last_lat = 0;
  int                 to_issue = 0;
  int                 rem [NUM_REQ];
  bit                 in_flight = 1'b0;
  bit                 seen_v = 1'b0;
  bit                 random_mode = 1'b0;
  logic [NUM_REQ-1:0] granted_now;
  logic [WIDTH-1:0]   m_a, m_b, last_sum;
  logic               m_cin, last_cout;
  logic [IDW-1:0]     last_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] vv, input int ptr);
    int j;
    rr_pick = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (ptr + k) % NUM_REQ;
      if (vv[j] && (rr_pick == '0)) rr_pick[j] = 1'b1;
    end
  endfunction

  function automatic logic [WIDTH-1:0] rnd_word();
    case ($urandom_range(7))
      0:       rnd_word = '0;
      1:       rnd_word = '1;
      2:       rnd_word = 32'h8000_0000;
      default: rnd_word = $urandom;
    endcase
  endfunction

  task automatic new_ops(input int i);
    a_op[i]   = rnd_word();
    b_op[i]   = rnd_word();
    cin_op[i] = 1'($urandom_range(1));
  endtask

  task automatic observe();
    logic [NUM_REQ-1:0] exp_rdy;
    logic               exp_valid;
    int                 w;
    exp_t               e;
    exp_rdy   = in_flight ? '0 : rr_pick(v, ptr_m);
    exp_valid = in_flight && (cyc >= grant_cyc + 2);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("busy", bus.busy, in_flight);
    chk("rsp_valid", bus.rsp_valid, exp_valid);
    chk("add_a", bus.add_a, m_a);
    chk("add_b", bus.add_b, m_b);
    chk("add_cin", bus.add_cin, m_cin);
    if (in_flight && bus.rsp_valid && !seen_v) begin
      seen_v   = 1'b1;
      last_lat = cyc - grant_cyc;
    end
    if (exp_valid && bus.rsp_valid) begin
      chk("rsp_sum", bus.rsp_sum, sb[0].res[WIDTH-1:0]);
      chk("rsp_cout", bus.rsp_cout, sb[0].res[WIDTH]);
      chk("rsp_id", bus.rsp_id, sb[0].id);
    end
    if (exp_valid && rr) begin
      e = sb.pop_front();
      last_sum  = bus.rsp_sum;
      last_cout = bus.rsp_cout;
      last_id   = bus.rsp_id;
      exp_done++;
      in_flight = 1'b0;
      resp_cyc.push_back(cyc);
      $display("rsp cyc=%0d id=%0d sum=%08h cout=%0d exp_id=%0d exp=%09h",
               cyc, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, e.id, e.res);
    end
    if (exp_rdy != '0) begin
      w = 0;
      for (int k = 0; k < NUM_REQ; k++) if (exp_rdy[k]) w = k;
      e.id  = IDW'(w);
      e.res = {1'b0, a_op[w]} + {1'b0, b_op[w]} + {{WIDTH{1'b0}}, cin_op[w]};
      sb.push_back(e);
      m_a = a_op[w];
      m_b = b_op[w];
      m_cin = cin_op[w];
      in_flight = 1'b1;
      seen_v = 1'b0;
      grant_cyc = cyc;
      ptr_m = (w + 1) % NUM_REQ;
      grant_log.push_back(w);
      granted_now[w] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    granted_now = '0;
    observe();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (granted_now[i]) begin
        rem[i]--;
        if (rem[i] > 0) new_ops(i);
        else v[i] = 1'b0;
      end
    end
    if (random_mode) begin
      rr = ($urandom_range(3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v[i] && (to_issue > 0) && ($urandom_range(2) == 0)) begin
          new_ops(i);
          rem[i] = 1;
          v[i] = 1'b1;
          to_issue--;
        end else if (v[i] && !granted_now[i] && ($urandom_range(15) == 0)) begin
          v[i] = 1'b0;
          rem[i] = 0;
          to_issue++;
        end
      end
    end
  endtask

  task automatic run_idle(input int max, input string tag);
    int n;
    n = 0;
    while (((v != '0) || in_flight || (to_issue > 0)) && (n < max)) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, (n < max), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v = '0;
    rr = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
    in_flight = 1'b0;
    ptr_m = 0;
    exp_done = 0;
    sb.delete();
    m_a = '0;
    m_b = '0;
    m_cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_sum", bus.rsp_sum, 0);
    chk("rst_rsp_cout", bus.rsp_cout, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_add_b", bus.add_b, 0);
    chk("rst_add_cin", bus.add_cin, 0);
    chk("rst_ops_done", bus.ops_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    v = '0;
    rr = 1'b0;
    cin_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
      rem[i] = 0;
    end

    // Reset state and idle behaviour with no requests.
    do_reset();
    repeat (3) cycle();

    // Single request from requester 2 exercising carry-out and wrap to zero.
    a_op[2] = 32'hFFFF_FFFF;
    b_op[2] = 32'h0000_0001;
    cin_op[2] = 1'b0;
    rem[2] = 1;
    v[2] = 1'b1;
    rr = 1'b1;
    #1 chk("t2_req_ready", bus.req_ready, 4'b0100);
    run_idle(50, "t2");
    chk("t2_sum", last_sum, 0);
    chk("t2_cout", last_cout, 1);
    chk("t2_id", last_id, 2);
    chk("t2_latency", last_lat, 2);
    chk("t2_ops_done", bus.ops_done, 1);

    // Fairness: all four continuously valid, two operations each.
    do_reset();
    grant_log.delete();
    resp_cyc.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = 2;
      new_ops(i);
    end
    v = '1;
    rr = 1'b1;
    run_idle(200, "t3");
    chk("t3_grants", grant_log.size(), 8);
    foreach (grant_log[k]) chk("t3_order", grant_log[k], k % NUM_REQ);
    for (int k = 1; k < resp_cyc.size(); k++)
      chk("t3_interval", resp_cyc[k] - resp_cyc[k-1], 3);
    chk("t3_ops_done", bus.ops_done, 8);

    // Backpressure: response held for five cycles while requester 3 waits.
    rr = 1'b0;
    rem[0] = 1;
    new_ops(0);
    v[0] = 1'b1;
    rem[3] = 1;
    new_ops(3);
    v[3] = 1'b1;
    n = 0;
    while (!bus.rsp_valid && (n < 20)) begin
      cycle();
      n++;
    end
    chk("t4_wait_timeout", (n < 20), 1);
    repeat (5) cycle();
    chk("t4_hold_valid", bus.rsp_valid, 1);
    chk("t4_ops_held", bus.ops_done, 8);
    rr = 1'b1;
    run_idle(50, "t4");
    chk("t4_ops_done", bus.ops_done, 10);

    // Reset while requester 1's operation is in EXEC.
    a_op[1] = 32'd5;
    b_op[1] = 32'd7;
    cin_op[1] = 1'b1;
    rem[1] = 1;
    v[1] = 1'b1;
    n = 0;
    while (!in_flight && (n < 20)) begin
      cycle();
      n++;
    end
    chk("t5_grant_timeout", (n < 20), 1);
    chk("t5_in_exec", bus.busy, 1);
    do_reset();
    repeat (4) cycle();
    grant_log.delete();
    rem[1] = 1;
    rem[3] = 1;
    new_ops(1);
    new_ops(3);
    v = 4'b1010;
    rr = 1'b1;
    run_idle(50, "t5");
    chk("t5_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("t5_first_grant", grant_log[0], 1);
    chk("t5_ops_done", bus.ops_done, 2);

    // 1000 random operations from random requesters with random backpressure.
    to_issue = 1000;
    random_mode = 1'b1;
    run_idle(20000, "t6");
    random_mode = 1'b0;
    rr = 1'b1;
    repeat (2) cycle();
    chk("t6_ops_done", bus.ops_done, CNT_W'(exp_done));
    chk("t6_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
